// File: rtl/upf_pkg.sv
// ---------------------------------------------------------------------------
// upf_pkg
// Shared definitions for the load/store control slice: uPower D-form primary
// opcodes, the ALU operation code driven to ALU_32, the sequencer state
// encoding and the decoder result record.
// ---------------------------------------------------------------------------
package upf_pkg;

  // Primary opcodes (instruction[31:26]) handled by this sequencer.
  localparam logic [5:0] OP_STW  = 6'd36;
  localparam logic [5:0] OP_LWZ  = 6'd32;
  localparam logic [5:0] OP_ADDI = 6'd14;

  // ALU_32 operation codes. Every supported instruction computes an address
  // or a sum, so only add is ever requested.
  localparam logic [3:0] ALU_NOP = 4'b0000;
  localparam logic [3:0] ALU_ADD = 4'b0010;

  // Sequencer states. HALT is terminal until reset.
  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_t;

  // Decoder result. At most one of the class bits is set, and only when
  // legal is set.
  typedef struct packed {
    logic is_store;
    logic is_load;
    logic is_alu_imm;
    logic legal;
  } decode_t;

  // Primary opcode field of a 32-bit instruction word.
  function automatic logic [5:0] opcode_of(input logic [31:0] word);
    return word[31:26];
  endfunction

endpackage

// File: rtl/ls_control_unit_if.sv
// ---------------------------------------------------------------------------
// ls_control_unit_if
// Bundle between the fetch/decode/control sequencer and its surroundings
// (instruction memory, data-memory handshake, load/store datapath).
//   instr_in     instruction word read combinationally at imem_addr
//   mem_ready    data memory accepts/completes the current access
//   imem_addr    current PC
//   instruction  instruction register (RS=[25:21], RA=[20:16], D=[15:0])
//   ALU_OP       ALU_32 operation
//   RegWrite     RegFile_32_32 write enable
//   MemRead      DataMemory read enable
//   MemWrite     DataMemory write enable
//   instr_done   one-cycle pulse in the cycle an instruction retires
//   illegal      sticky: an undecodable opcode was seen
// master: the control unit. slave: memories/datapath side.
// ---------------------------------------------------------------------------
interface ls_control_unit_if #(
  parameter int N = 32
);
  logic [N-1:0] instr_in;
  logic         mem_ready;
  logic [N-1:0] imem_addr;
  logic [N-1:0] instruction;
  logic [3:0]   ALU_OP;
  logic         RegWrite;
  logic         MemRead;
  logic         MemWrite;
  logic         instr_done;
  logic         illegal;

  modport master (
    input  instr_in, mem_ready,
    output imem_addr, instruction, ALU_OP, RegWrite, MemRead, MemWrite,
           instr_done, illegal
  );

  modport slave (
    output instr_in, mem_ready,
    input  imem_addr, instruction, ALU_OP, RegWrite, MemRead, MemWrite,
           instr_done, illegal
  );
endinterface

// File: rtl/ls_decode.sv
// ---------------------------------------------------------------------------
// ls_decode
// Combinational primary-opcode decoder.
//   opcode  instruction[31:26] of the instruction register
//   dec     {is_store, is_load, is_alu_imm, legal}
// ---------------------------------------------------------------------------
module ls_decode
  import upf_pkg::*;
(
  input  logic [5:0] opcode,
  output decode_t    dec
);

  // NOTE: every output of a combinational block gets a default before any
  // branch; a path that leaves it unassigned would infer a latch.
  always_comb begin
    dec = '0;
    case (opcode)
      OP_STW:  begin dec.is_store   = 1'b1; dec.legal = 1'b1; end
      OP_LWZ:  begin dec.is_load    = 1'b1; dec.legal = 1'b1; end
      OP_ADDI: begin dec.is_alu_imm = 1'b1; dec.legal = 1'b1; end
      default: dec = '0;
    endcase
  end

endmodule

// File: rtl/ls_control_unit.sv
// ---------------------------------------------------------------------------
// ls_control_unit
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer in front of the load/store
// datapath. Holds PC and IR, decodes stw/lwz/addi and drives the datapath
// strobes. Stalls in MEM until mem_ready.
//   clk  rising-edge clock
//   rst  synchronous reset, active low
//   bus  ls_control_unit_if master modport (see interface header)
// Strobes (ALU_OP, RegWrite, MemRead, MemWrite) are decoded from the state
// register and IR only. instr_done marks the retiring cycle; for stw that is
// the MEM cycle in which mem_ready is high, so it is qualified by mem_ready.
// ---------------------------------------------------------------------------
module ls_control_unit
  import upf_pkg::*;
#(
  parameter int           N        = 32,
  parameter logic [N-1:0] RESET_PC = '0,
  parameter int           PC_STEP  = 4
) (
  input  logic               clk,
  input  logic               rst,
  ls_control_unit_if.master  bus
);

  state_t       state;
  state_t       state_next;
  logic [N-1:0] pc;
  logic [N-1:0] ir;
  logic         illegal_q;
  decode_t      dec;
  logic         retire;

  // Decode always looks at the IR, so the decision in DECODE and every later
  // state is based on the word latched in FETCH.
  ls_decode u_decode (
    .opcode (opcode_of(ir[31:0])),
    .dec    (dec)
  );

  // Final cycle of an instruction: WB, or a store's MEM cycle that completes.
  assign retire = (state == WB) ||
                  (state == MEM && dec.is_store && bus.mem_ready);

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= FETCH;
      pc        <= RESET_PC;
      ir        <= '0;
      illegal_q <= 1'b0;
    end else begin
      state <= state_next;
      if (state == FETCH) begin
        ir <= bus.instr_in;
      end
      if (retire) begin
        pc <= pc + N'(PC_STEP);   // wraps modulo 2^N by width
      end
      if (state == DECODE && !dec.legal) begin
        illegal_q <= 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      FETCH:  state_next = DECODE;
      DECODE: state_next = dec.legal ? EXEC : HALT;
      EXEC: begin
        if (dec.is_store || dec.is_load) begin
          state_next = MEM;
        end else if (dec.is_alu_imm) begin
          state_next = WB;
        end else begin
          state_next = HALT;
        end
      end
      MEM: begin
        // mem_ready only matters here; outside MEM it is never looked at.
        if (bus.mem_ready) begin
          state_next = dec.is_store ? FETCH : WB;
        end
      end
      WB:      state_next = FETCH;
      HALT:    state_next = HALT;
      default: state_next = FETCH;
    endcase
  end

  always_comb begin
    bus.ALU_OP   = ALU_NOP;
    bus.RegWrite = 1'b0;
    bus.MemRead  = 1'b0;
    bus.MemWrite = 1'b0;
    case (state)
      EXEC: bus.ALU_OP = ALU_ADD;
      MEM: begin
        bus.ALU_OP   = ALU_ADD;
        bus.MemWrite = dec.is_store;
        bus.MemRead  = dec.is_load;
      end
      WB: begin
        bus.ALU_OP   = ALU_ADD;
        bus.RegWrite = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.imem_addr   = pc;
  assign bus.instruction = ir;
  assign bus.instr_done  = retire;
  assign bus.illegal     = illegal_q;

endmodule

// File: tb/tb_ls_control_unit.sv
// ---------------------------------------------------------------------------
// tb_ls_control_unit
// Two control units share clk/rst/instr_in/mem_ready; one resets to PC 0,
// the other to 32'hFFFF_FFF8 to exercise PC wrap. An instruction-level model
// (cycle count within the instruction, memory-phase-done flag) predicts every
// output each cycle; directed checks pin the model to hand-computed values.
// ---------------------------------------------------------------------------
module tb_ls_control_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr_in;
  logic        mem_ready;
  bit          cmp_en = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ls_control_unit_if #(.N(32)) bus0 ();
  ls_control_unit_if #(.N(32)) bus1 ();

  assign bus0.instr_in  = instr_in;
  assign bus0.mem_ready = mem_ready;
  assign bus1.instr_in  = instr_in;
  assign bus1.mem_ready = mem_ready;

  ls_control_unit #(.N(32), .RESET_PC(32'h0000_0000), .PC_STEP(4)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  ls_control_unit #(.N(32), .RESET_PC(32'hFFFF_FFF8), .PC_STEP(4)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] instr;
    logic [3:0]  alu;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        done;
    logic        ill;
  } obs_t;

  obs_t obs [2];
  assign obs[0] = {bus0.imem_addr, bus0.instruction, bus0.ALU_OP, bus0.RegWrite,
                   bus0.MemRead, bus0.MemWrite, bus0.instr_done, bus0.illegal};
  assign obs[1] = {bus1.imem_addr, bus1.instruction, bus1.ALU_OP, bus1.RegWrite,
                   bus1.MemRead, bus1.MemWrite, bus1.instr_done, bus1.illegal};

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- instruction-level model ----------------
  // cyc counts cycles since the instruction's fetch cycle (0 = fetch).
  // memdone marks that a load's memory access has completed.
  localparam logic [31:0] RST_PC [2] = '{32'h0000_0000, 32'hFFFF_FFF8};

  logic [31:0] m_pc [2];
  logic [31:0] m_ir [2];
  bit          m_ill [2];
  bit          m_halt [2];
  bit          m_memdone [2];
  int          m_cyc [2];

  function automatic bit is_st(input logic [31:0] w); return w[31:26] == 6'd36; endfunction
  function automatic bit is_ld(input logic [31:0] w); return w[31:26] == 6'd32; endfunction
  function automatic bit is_ad(input logic [31:0] w); return w[31:26] == 6'd14; endfunction

  function automatic bit in_mem(input int i);
    return !m_halt[i] && m_cyc[i] >= 3 && (is_st(m_ir[i]) || is_ld(m_ir[i]))
           && !m_memdone[i];
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst) begin
        m_pc[i] <= RST_PC[i]; m_ir[i] <= '0; m_ill[i] <= 1'b0;
        m_halt[i] <= 1'b0; m_memdone[i] <= 1'b0; m_cyc[i] <= 0;
      end else if (!m_halt[i]) begin
        if (m_cyc[i] == 0) begin
          m_ir[i] <= instr_in; m_cyc[i] <= 1;
        end else if (m_cyc[i] == 1) begin
          if (is_st(m_ir[i]) || is_ld(m_ir[i]) || is_ad(m_ir[i])) m_cyc[i] <= 2;
          else begin m_halt[i] <= 1'b1; m_ill[i] <= 1'b1; end
        end else if (m_cyc[i] == 2) begin
          m_cyc[i] <= 3;
        end else if (in_mem(i) && !mem_ready) begin
          m_cyc[i] <= m_cyc[i] + 1;                 // stall
        end else if (in_mem(i) && is_ld(m_ir[i])) begin
          m_memdone[i] <= 1'b1; m_cyc[i] <= m_cyc[i] + 1;
        end else begin                              // retiring cycle
          m_pc[i] <= m_pc[i] + 32'd4; m_cyc[i] <= 0; m_memdone[i] <= 1'b0;
        end
      end
    end
  end

  // ---------------- per-cycle comparison ----------------
  always @(negedge clk) begin
    if (cmp_en) begin
      for (int i = 0; i < 2; i++) begin
        automatic bit e_mw = in_mem(i) && is_st(m_ir[i]);
        automatic bit e_mr = in_mem(i) && is_ld(m_ir[i]);
        automatic bit e_rw = !m_halt[i] && m_cyc[i] >= 3 &&
                             (is_ad(m_ir[i]) || (is_ld(m_ir[i]) && m_memdone[i]));
        automatic logic [3:0] e_alu = (!m_halt[i] && m_cyc[i] >= 2) ? 4'b0010 : 4'b0000;
        check($sformatf("model d%0d imem_addr", i), obs[i].addr, m_pc[i]);
        check($sformatf("model d%0d instruction", i), obs[i].instr, m_ir[i]);
        check($sformatf("model d%0d ALU_OP", i), 32'(obs[i].alu), 32'(e_alu));
        check($sformatf("model d%0d RegWrite", i), 32'(obs[i].rw), 32'(e_rw));
        check($sformatf("model d%0d MemRead", i), 32'(obs[i].mr), 32'(e_mr));
        check($sformatf("model d%0d MemWrite", i), 32'(obs[i].mw), 32'(e_mw));
        check($sformatf("model d%0d instr_done", i), 32'(obs[i].done),
              32'(e_rw || (e_mw && mem_ready)));
        check($sformatf("model d%0d illegal", i), 32'(obs[i].ill), 32'(m_ill[i]));
        check($sformatf("d%0d strobe exclusion", i),
              32'((obs[i].mr && obs[i].mw) || (obs[i].rw && (obs[i].mr || obs[i].mw))), 32'd0);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    next_cycle();
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; instr_in = '0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cmp_en = 1'b1;

    // stw R1,2(R4), no stall: F D E M
    instr_in = 32'h9024_0002; mem_ready = 1'b1;
    do_reset();                                  #3;   // cycle 1
    check("stw c1 imem_addr", bus0.imem_addr, 32'h0);
    check("stw c1 instruction", bus0.instruction, 32'h0);
    check("stw c1 d1 imem_addr", bus1.imem_addr, 32'hFFFF_FFF8);
    next_cycle(); #3;                                   // cycle 2
    check("stw c2 instruction", bus0.instruction, 32'h9024_0002);
    check("stw c2 ALU_OP", 32'(bus0.ALU_OP), 32'h0);
    next_cycle(); #3;                                   // cycle 3
    check("stw c3 ALU_OP", 32'(bus0.ALU_OP), 32'h2);
    check("stw c3 MemWrite", 32'(bus0.MemWrite), 32'h0);
    next_cycle(); #3;                                   // cycle 4
    check("stw c4 MemWrite", 32'(bus0.MemWrite), 32'h1);
    check("stw c4 instr_done", 32'(bus0.instr_done), 32'h1);
    check("stw c4 imem_addr", bus0.imem_addr, 32'h0);
    next_cycle(); #3;                                   // cycle 5
    check("stw c5 imem_addr", bus0.imem_addr, 32'h4);
    check("stw c5 MemWrite", 32'(bus0.MemWrite), 32'h0);
    check("stw c5 d1 imem_addr", bus1.imem_addr, 32'hFFFF_FFFC);

    // lwz: F D E M W
    instr_in = 32'h8022_0008; mem_ready = 1'b1;
    do_reset();
    repeat (3) next_cycle(); #3;                        // cycle 4
    check("lwz c4 MemRead", 32'(bus0.MemRead), 32'h1);
    check("lwz c4 RegWrite", 32'(bus0.RegWrite), 32'h0);
    next_cycle(); #3;                                   // cycle 5
    check("lwz c5 RegWrite", 32'(bus0.RegWrite), 32'h1);
    check("lwz c5 MemRead", 32'(bus0.MemRead), 32'h0);
    check("lwz c5 instr_done", 32'(bus0.instr_done), 32'h1);
    next_cycle(); #3;                                   // cycle 6
    check("lwz c6 imem_addr", bus0.imem_addr, 32'h4);
    check("lwz c6 RegWrite", 32'(bus0.RegWrite), 32'h0);

    // stw stalled three cycles in MEM
    instr_in = 32'h9024_0002; mem_ready = 1'b0;
    do_reset();
    repeat (2) next_cycle();                            // cycle 3
    for (int k = 4; k <= 7; k++) begin
      next_cycle();
      if (k == 7) mem_ready = 1'b1;
      #3;
      check($sformatf("stall c%0d MemWrite", k), 32'(bus0.MemWrite), 32'h1);
      check($sformatf("stall c%0d ALU_OP", k), 32'(bus0.ALU_OP), 32'h2);
      check($sformatf("stall c%0d imem_addr", k), bus0.imem_addr, 32'h0);
      check($sformatf("stall c%0d instr_done", k), 32'(bus0.instr_done),
            (k == 7) ? 32'h1 : 32'h0);
    end
    next_cycle(); #3;                                   // cycle 8
    check("stall c8 imem_addr", bus0.imem_addr, 32'h4);
    check("stall c8 MemWrite", 32'(bus0.MemWrite), 32'h0);

    // illegal opcode 63 -> HALT
    instr_in = 32'hFC00_0000; mem_ready = 1'b1;
    do_reset();
    next_cycle(); #3;                                   // cycle 2 (decode)
    check("ill c2 illegal", 32'(bus0.illegal), 32'h0);
    next_cycle(); #3;                                   // cycle 3
    check("ill c3 illegal", 32'(bus0.illegal), 32'h1);
    for (int k = 0; k < 20; k++) begin
      next_cycle();
      mem_ready = 1'($urandom_range(0, 1));
      #3;
      check("halt illegal", 32'(bus0.illegal), 32'h1);
      check("halt strobes", {28'h0, bus0.RegWrite, bus0.MemRead, bus0.MemWrite,
                             bus0.instr_done}, 32'h0);
      check("halt ALU_OP", 32'(bus0.ALU_OP), 32'h0);
      check("halt imem_addr", bus0.imem_addr, 32'h0);
      check("halt d1 imem_addr", bus1.imem_addr, 32'hFFFF_FFF8);
    end
    do_reset(); #3;
    check("ill reset illegal", 32'(bus0.illegal), 32'h0);
    check("ill reset imem_addr", bus0.imem_addr, 32'h0);
    check("ill reset instruction", bus0.instruction, 32'h0);

    // reset while a load is stalled in MEM
    instr_in = 32'h8022_0008; mem_ready = 1'b0;
    do_reset();
    repeat (3) next_cycle(); #3;                        // cycle 4
    check("abort MemRead before", 32'(bus0.MemRead), 32'h1);
    do_reset(); #3;
    check("abort MemRead after", 32'(bus0.MemRead), 32'h0);
    check("abort imem_addr", bus0.imem_addr, 32'h0);
    check("abort ALU_OP", 32'(bus0.ALU_OP), 32'h0);
    for (int k = 0; k < 8; k++) begin
      next_cycle(); #3;
      check("abort no RegWrite", 32'(bus0.RegWrite), 32'h0);
    end

    // back-to-back addi, PC wrap on the second unit
    instr_in = 32'h3820_0005; mem_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      #3;
      check($sformatf("addi%0d d0 imem_addr", i), bus0.imem_addr, 32'(4 * i));
      check($sformatf("addi%0d d1 imem_addr", i), bus1.imem_addr,
            32'hFFFF_FFF8 + 32'(4 * i));
      next_cycle(); #3;
      check($sformatf("addi%0d c2 RegWrite", i), 32'(bus1.RegWrite), 32'h0);
      next_cycle(); #3;
      check($sformatf("addi%0d c3 RegWrite", i), 32'(bus1.RegWrite), 32'h0);
      next_cycle(); #3;
      check($sformatf("addi%0d c4 RegWrite", i), 32'(bus1.RegWrite), 32'h1);
      check($sformatf("addi%0d c4 instr_done", i), 32'(bus1.instr_done), 32'h1);
      next_cycle();
    end
    #3;
    check("addi end d1 imem_addr", bus1.imem_addr, 32'h0000_0004);
    check("addi end d0 imem_addr", bus0.imem_addr, 32'h0000_000C);

    repeat (2) next_cycle();
    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ls_control_unit.md
Name: ls_control_unit

Overview:
Multi-cycle fetch/decode/control sequencer sitting directly upstream of the load/store datapath (ALU_32, RegFile_32_32, DataMemory).
- Holds the PC and the instruction register.
- Decodes uPower D-form opcodes and steps each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Drives instruction, ALU_OP, RegWrite, MemRead and MemWrite exactly as the datapath consumes them.
- Stalls in MEM on a memory-ready handshake.

Parameters:
N, 32, instruction/PC width
RESET_PC, 32'h0000_0000, PC value after reset
PC_STEP, 4, PC increment per retired instruction

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous reset, active-low: state cleared on a rising clk edge where rst==0
instr_in  input  N  instruction word from instruction memory at imem_addr (combinational read)
mem_ready  input  1  data memory accepts/completes the access this cycle
imem_addr  output  N  current PC
instruction  output  N  registered instruction (IR) to datapath; RS=[25:21], RA=[20:16], D=[15:0]
ALU_OP  output  4  ALU operation; 4'b0010 = add
RegWrite  output  1  register-file write enable
MemRead  output  1  data-memory read enable
MemWrite  output  1  data-memory write enable
instr_done  output  1  one-cycle pulse when an instruction retires
illegal  output  1  sticky; undecodable opcode seen

Behaviour:
- Reset: on a clk edge with rst==0, the following apply at the next edge, including mid-instruction:
  - state=FETCH, imem_addr=RESET_PC, instruction=0
  - ALU_OP=0, RegWrite=MemRead=MemWrite=0, instr_done=0, illegal=0
  - An in-flight MEM stall is abandoned.
- Opcode=instruction[31:26]. Decoded:
  - 36 stw
  - 32 lwz
  - 14 addi
  - All others are illegal.
- FETCH: IR<=instr_in; next state DECODE. All strobes 0.
- DECODE:
  - Legal opcode -> EXEC.
  - Illegal opcode -> HALT; illegal<=1.
  - Strobes 0.
- EXEC: ALU_OP=4'b0010.
  - stw/lwz -> MEM.
  - addi -> WB.
- MEM: ALU_OP=4'b0010 held. MemWrite=1 (stw) or MemRead=1 (lwz).
  - Stays in MEM while mem_ready==0, strobes held stable.
  - mem_ready==1: stw -> FETCH (retire); lwz -> WB.
- WB: RegWrite=1 for exactly one cycle; ALU_OP=4'b0010 held; -> FETCH (retire).
- Retire:
  - On the edge leaving the final state: imem_addr<=imem_addr+PC_STEP, wrapping modulo 2^N.
  - instr_done=1 during that final state cycle only.
- HALT: terminal. All strobes 0, PC frozen, illegal=1, until reset.
- Latency without stalls:
  - stw: 4 cycles (F,D,E,M)
  - lwz: 5 cycles (F,D,E,M,W)
  - addi: 4 cycles (F,D,E,W)
  - Each MEM cycle with mem_ready==0 adds 1 cycle.
- Timing and mutual exclusion:
  - Control outputs are Moore: decoded from the registered state and IR only, never from instr_in or mem_ready.
  - MemRead and MemWrite are never both 1.
  - RegWrite is never 1 together with MemRead or MemWrite.
- instruction changes only in FETCH, so the datapath sees a stable IR for the whole instruction.
- mem_ready is ignored outside MEM.
- PC wrap-around: 32'hFFFF_FFFC + 4 -> 0, no flag.

Decomposition:
- Shared package upf_pkg:
  - opcode constants OP_STW=36, OP_LWZ=32, OP_ADDI=14
  - ALU op constant ALU_ADD=4'b0010
  - state enum FETCH/DECODE/EXEC/MEM/WB/HALT (3-bit encoding)
- One natural sub-module, ls_decode: combinational opcode -> {is_store, is_load, is_alu_imm, legal}.
- FSM, PC and IR stay in ls_control_unit.

Test Plan:
- Reset, then rst=1, instr_in=32'h9024_0002 (stw R1,2(R4)), mem_ready=1:
  - instruction=32'h9024_0002 from cycle 2.
  - ALU_OP=0010 in cycles 3-4; MemWrite=1 in cycle 4 only.
  - RegWrite never 1.
  - imem_addr 0 -> 4 after cycle 4; instr_done pulses in cycle 4.
- lwz 32'h8022_0008, mem_ready=1:
  - MemRead=1 in cycle 4.
  - RegWrite=1 in cycle 5 only.
  - imem_addr=4 after cycle 5.
- stw with mem_ready=0 for 3 cycles, then 1:
  - MemWrite and ALU_OP held for 4 consecutive cycles.
  - PC unchanged until the mem_ready=1 cycle; total 7 cycles.
- Opcode 63 (32'hFC00_0000):
  - illegal=1 after DECODE.
  - All strobes 0 and imem_addr frozen for 20 cycles.
  - rst=0 for one edge clears illegal and returns to FETCH at RESET_PC.
- rst=0 asserted while stalled in MEM (MemRead=1):
  - Next edge: MemRead=0, state FETCH, imem_addr=0.
  - No RegWrite pulse follows.
- Back-to-back addi 32'h3820_0005 x3 with RESET_PC=32'hFFFF_FFF8:
  - RegWrite one pulse per instruction.
  - imem_addr sequence FFFF_FFF8 -> FFFF_FFFC -> 0 -> 4.
